avr_control: RTL and testbench
==============================

// Module: avr_control
// PURPOSE
//  Sequencing controller for the single-issue AVR core. Classifies the held instruction, drives the fetch
//  unit's pc_src/jmp, gates register-file and SREG writes, and runs the data-memory handshake for LD/ST.
//  Sits between avr_fetch (cur_instr in, pc_src/jmp out) and the ALU/register file. Program memory is
//  combinational: a new PC yields that word as instr on the next cycle, so no flush bubbles are needed.
// PARAMETERS
//  PC_W          16  PC/jump width
//  MEM_WAIT_MAX  0   max MEM_WAIT cycles before abort; 0 = wait forever
// PORTS
//  CLK        in   1     clock
//  RST        in   1     synchronous reset, active-high
//  instr      in   16    held instruction word (cur_instr)
//  sreg       in   8     {I,T,H,S,V,N,Z,C}
//  d_ready    in   1     data memory completes access this cycle
//  pc_src     out  3     000 reset,001 hold,010 +1,011 +2,100 PC+jmp,101 jmp
//  jmp        out  PC_W  relative offset or absolute target
//  reg_we     out  1     write Rd_di to Rd this cycle
//  sreg_we    out  1     commit ALU flags this cycle
//  d_req      out  1     data access request
//  d_we       out  1     1=store,0=load (valid with d_req)
//  d_ptr_sel  out  2     0=X,1=Y,2=Z
//  mem_timeout out 1     one-cycle pulse on MEM_WAIT abort
//  state      out  2     FSM state (debug)
// BEHAVIOUR
//  - Outputs combinational from state+instr; while RST=1 all outputs 0, pc_src=000, state<=RESET.
//  - States: RESET(0) EXEC(1) WORD2(2) MEM_WAIT(3).
//  - RESET: pc_src=000 (prog_addr=0); next EXEC, so first EXEC cycle sees word 0.
//  - EXEC classes (others = NOP: pc_src=010, no writes):
//    ADD/ADC 000x11, SUB 000110, SUBI 0101: reg_we=1,sreg_we=1,pc_src=010.
//    LDI 1110: reg_we=1,sreg_we=0,pc_src=010.
//    RJMP 1100 k12: pc_src=100, jmp=sext(k12)+1 (wraps mod 2^PC_W).
//    JMP 1001_010k_kkkk_110k: pc_src=010, ->WORD2. k[21:16] ignored.
//    LD/ST X 1001_00sd_dddd_1100, Y 1000_00sd_dddd_1000, Z 1000_00sd_dddd_0000 (s=1 store):
//      d_req=1, d_we=s, pc_src=001; d_ready same cycle -> reg_we=!s, pc_src=010, stay EXEC;
//      else ->MEM_WAIT.
//  - WORD2: instr is target; pc_src=101, jmp=instr; no writes; ->EXEC.
//  - MEM_WAIT: hold d_req/d_we/d_ptr_sel, pc_src=001, wait counter++. On d_ready: reg_we=!s, pc_src=010,
//    ->EXEC, counter<=0. If MEM_WAIT_MAX!=0 and counter==MEM_WAIT_MAX-1 without d_ready: d_req=0,
//    mem_timeout=1, pc_src=010, no reg_we, ->EXEC. d_ready and timeout same cycle: d_ready wins.
//  - RST mid-WORD2/MEM_WAIT: access abandoned, d_req=0 that cycle, counter cleared, ->RESET.
//  - d_ready outside a request is ignored.
// CONFIGURATION
//  AVR_BRANCH_EN defined: BRBS 1111_00kk_kkkk_ksss / BRBC 1111_01...; taken if sreg[s]==!instr[10]:
//    pc_src=100, jmp=sext(k7)+1; not taken pc_src=010. No writes either way.
//  Undefined: BRBS/BRBC decode as NOP (pc_src=010).
// STRUCTURE
//  avr_pkg: pc_src codes, state encodings, opcode masks/values, d_ptr_sel codes.
//  Sub-module avr_decode: combinational classifier instr -> class one-hot + store bit + ptr_sel;
//  avr_control holds FSM, wait counter, output muxing.
// TESTING
//  RST 1 cycle, instr=0 -> RESET pc_src=000, then EXEC pc_src=010, all enables 0.
//  ADD 0x0C01 -> reg_we=1,sreg_we=1,pc_src=010; LDI 0xE0A5 -> reg_we=1,sreg_we=0.
//  RJMP 0xCFFE -> pc_src=100, jmp=0xFFFF; RJMP 0xC7FF -> jmp=0x0800.
//  JMP 0x940C then 0x0123 -> pc_src 010 then 101,jmp=0x0123, state 1->2->1.
//  LD X 0x900C, d_ready low 3 cycles then high -> d_req 4 cycles, pc_src=001 x3, reg_we on 4th;
//    MEM_WAIT_MAX=2, d_ready never -> mem_timeout pulse on 2nd cycle, pc_src=010, no reg_we.
//  AVR_BRANCH_EN, BRBS Z (0xF3F9,k=-1), sreg=0x02 -> pc_src=100,jmp=0x0000; sreg=0 -> 010.

Source files
------------

// File: rtl/avr_pkg.sv
// Shared encodings for the AVR sequencing controller: PC-source codes, FSM states,
// pointer selects and opcode mask/value pairs used by the instruction classifier.
package avr_pkg;

    typedef enum logic [2:0] {
        PC_RESET = 3'b000,
        PC_HOLD  = 3'b001,
        PC_INC1  = 3'b010,
        PC_INC2  = 3'b011,
        PC_REL   = 3'b100,
        PC_ABS   = 3'b101
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_RESET    = 2'd0,
        ST_EXEC     = 2'd1,
        ST_WORD2    = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_e;

    localparam logic [1:0] PTR_X = 2'd0;
    localparam logic [1:0] PTR_Y = 2'd1;
    localparam logic [1:0] PTR_Z = 2'd2;

    // ADD and ADC share one pattern: bit 12 is the carry-in select.
    localparam logic [15:0] ADD_MASK  = 16'hEC00, ADD_VAL  = 16'h0C00;
    localparam logic [15:0] SUB_MASK  = 16'hFC00, SUB_VAL  = 16'h1800;
    localparam logic [15:0] SUBI_MASK = 16'hF000, SUBI_VAL = 16'h5000;
    localparam logic [15:0] LDI_MASK  = 16'hF000, LDI_VAL  = 16'hE000;
    localparam logic [15:0] RJMP_MASK = 16'hF000, RJMP_VAL = 16'hC000;
    localparam logic [15:0] JMP_MASK  = 16'hFE0E, JMP_VAL  = 16'h940C;
    localparam logic [15:0] MEM_MASK  = 16'hFC0F;
    localparam logic [15:0] MEMX_VAL  = 16'h900C;
    localparam logic [15:0] MEMY_VAL  = 16'h8008;
    localparam logic [15:0] MEMZ_VAL  = 16'h8000;
    localparam logic [15:0] BR_MASK   = 16'hF800, BR_VAL   = 16'hF000;

    typedef struct packed {
        logic alu;
        logic ldi;
        logic rjmp;
        logic jmp;
        logic mem;
        logic br;
    } instr_class_t;

    function automatic logic op_match(input logic [15:0] word,
                                      input logic [15:0] mask,
                                      input logic [15:0] val);
        return (word & mask) == val;
    endfunction

endpackage

// File: rtl/avr_decode.sv
// Combinational instruction classifier: one-hot class, store bit and pointer select.
// Conditional branches (BRBS/BRBC) are recognised only when AVR_BRANCH_EN is defined.
module avr_decode
    import avr_pkg::*;
(
    input  logic [15:0]  instr_i,
    output instr_class_t cls_o,
    output logic         store_o,
    output logic [1:0]   ptr_sel_o
);

    logic mem_x, mem_y, mem_z;

    always_comb begin
        mem_x = op_match(instr_i, MEM_MASK, MEMX_VAL);
        mem_y = op_match(instr_i, MEM_MASK, MEMY_VAL);
        mem_z = op_match(instr_i, MEM_MASK, MEMZ_VAL);

        cls_o      = '0;
        cls_o.alu  = op_match(instr_i, ADD_MASK, ADD_VAL)
                   | op_match(instr_i, SUB_MASK, SUB_VAL)
                   | op_match(instr_i, SUBI_MASK, SUBI_VAL);
        cls_o.ldi  = op_match(instr_i, LDI_MASK, LDI_VAL);
        cls_o.rjmp = op_match(instr_i, RJMP_MASK, RJMP_VAL);
        cls_o.jmp  = op_match(instr_i, JMP_MASK, JMP_VAL);
        cls_o.mem  = mem_x | mem_y | mem_z;
`ifdef AVR_BRANCH_EN
        cls_o.br   = op_match(instr_i, BR_MASK, BR_VAL);
`else
        cls_o.br   = 1'b0;
`endif

        store_o = instr_i[9];
        if (mem_y) begin
            ptr_sel_o = PTR_Y;
        end else if (mem_z) begin
            ptr_sel_o = PTR_Z;
        end else begin
            ptr_sel_o = PTR_X;
        end
    end

endmodule

// File: rtl/avr_control.sv
// Sequencing controller for the single-issue AVR core: FSM, data-memory wait counter
// and output muxing. Optional BRBS/BRBC support is enabled by defining AVR_BRANCH_EN.
module avr_control
    import avr_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int MEM_WAIT_MAX = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [15:0]     instr,
    input  logic [7:0]      sreg,
    input  logic            d_ready,
    output logic [2:0]      pc_src,
    output logic [PC_W-1:0] jmp,
    output logic            reg_we,
    output logic            sreg_we,
    output logic            d_req,
    output logic            d_we,
    output logic [1:0]      d_ptr_sel,
    output logic            mem_timeout,
    output logic [1:0]      state
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 2);
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        CNT_W'((MEM_WAIT_MAX == 0) ? 0 : MEM_WAIT_MAX - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             store_q, store_d;
    logic [1:0]       ptr_q, ptr_d;

    instr_class_t     cls;
    logic             dec_store;
    logic [1:0]       dec_ptr;
    logic [PC_W-1:0]  rjmp_tgt, br_tgt;
    logic             br_taken, wait_expired;
    pc_src_e          pc_src_c;

    avr_decode u_decode (
        .instr_i   (instr),
        .cls_o     (cls),
        .store_o   (dec_store),
        .ptr_sel_o (dec_ptr)
    );

    // Relative targets are offset+1 so the fetch unit can simply add them to PC.
    assign rjmp_tgt = {{(PC_W-12){instr[11]}}, instr[11:0]} + PC_W'(1);
    assign br_tgt   = {{(PC_W-7){instr[9]}}, instr[9:3]} + PC_W'(1);
    assign br_taken = (sreg[instr[2:0]] == !instr[10]);
    // The EXEC request cycle counts as the first wait cycle.
    assign wait_expired = (MEM_WAIT_MAX != 0) && (cnt_q >= CNT_LIMIT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            store_q <= 1'b0;
            ptr_q   <= PTR_X;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        store_d     = store_q;
        ptr_d       = ptr_q;
        pc_src_c    = PC_INC1;
        jmp         = '0;
        reg_we      = 1'b0;
        sreg_we     = 1'b0;
        d_req       = 1'b0;
        d_we        = 1'b0;
        d_ptr_sel   = PTR_X;
        mem_timeout = 1'b0;

        unique case (state_q)
            ST_RESET: begin
                pc_src_c = PC_RESET;
                cnt_d    = '0;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                if (cls.alu) begin
                    reg_we  = 1'b1;
                    sreg_we = 1'b1;
                end else if (cls.ldi) begin
                    reg_we = 1'b1;
                end else if (cls.rjmp) begin
                    pc_src_c = PC_REL;
                    jmp      = rjmp_tgt;
                end else if (cls.jmp) begin
                    state_d = ST_WORD2;
                end else if (cls.mem) begin
                    d_req     = 1'b1;
                    d_we      = dec_store;
                    d_ptr_sel = dec_ptr;
                    store_d   = dec_store;
                    ptr_d     = dec_ptr;
                    if (d_ready) begin
                        reg_we = !dec_store;
                    end else begin
                        pc_src_c = PC_HOLD;
                        cnt_d    = CNT_W'(1);
                        state_d  = ST_MEM_WAIT;
                    end
                end else if (cls.br && br_taken) begin
                    pc_src_c = PC_REL;
                    jmp      = br_tgt;
                end
            end
            ST_WORD2: begin
                pc_src_c = PC_ABS;
                jmp      = PC_W'(instr);
                state_d  = ST_EXEC;
            end
            ST_MEM_WAIT: begin
                d_req     = 1'b1;
                d_we      = store_q;
                d_ptr_sel = ptr_q;
                pc_src_c  = PC_HOLD;
                cnt_d     = cnt_q + CNT_W'(1);
                if (d_ready) begin
                    reg_we   = !store_q;
                    pc_src_c = PC_INC1;
                    cnt_d    = '0;
                    state_d  = ST_EXEC;
                end else if (wait_expired) begin
                    d_req       = 1'b0;
                    d_we        = 1'b0;
                    d_ptr_sel   = PTR_X;
                    mem_timeout = 1'b1;
                    pc_src_c    = PC_INC1;
                    cnt_d       = '0;
                    state_d     = ST_EXEC;
                end
            end
            default: state_d = ST_RESET;
        endcase

        // Reset overrides everything combinationally so an in-flight access drops at once.
        if (RST) begin
            state_d     = ST_RESET;
            cnt_d       = '0;
            pc_src_c    = PC_RESET;
            jmp         = '0;
            reg_we      = 1'b0;
            sreg_we     = 1'b0;
            d_req       = 1'b0;
            d_we        = 1'b0;
            d_ptr_sel   = PTR_X;
            mem_timeout = 1'b0;
        end
    end

    assign pc_src = pc_src_c;
    assign state  = RST ? ST_RESET : state_q;

endmodule

// File: tb/tb_avr_control.sv
// Directed bench for avr_control: a default instance (unbounded wait) and a second
// instance with MEM_WAIT_MAX=2 for the timeout path. Branch checks follow AVR_BRANCH_EN.
module tb_avr_control;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] instr;
    logic [7:0]  sreg;
    logic        d_ready;

    logic [2:0]  pc_src, pc_src_t;
    logic [15:0] jmp, jmp_t;
    logic        reg_we, reg_we_t, sreg_we, sreg_we_t;
    logic        d_req, d_req_t, d_we, d_we_t, mem_timeout, mem_timeout_t;
    logic [1:0]  d_ptr_sel, d_ptr_sel_t, state, state_t;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    avr_control #(.PC_W(16), .MEM_WAIT_MAX(0)) dut (
        .CLK(CLK), .RST(RST), .instr(instr), .sreg(sreg), .d_ready(d_ready),
        .pc_src(pc_src), .jmp(jmp), .reg_we(reg_we), .sreg_we(sreg_we),
        .d_req(d_req), .d_we(d_we), .d_ptr_sel(d_ptr_sel),
        .mem_timeout(mem_timeout), .state(state)
    );

    avr_control #(.PC_W(16), .MEM_WAIT_MAX(2)) dut_to (
        .CLK(CLK), .RST(RST), .instr(instr), .sreg(sreg), .d_ready(d_ready),
        .pc_src(pc_src_t), .jmp(jmp_t), .reg_we(reg_we_t), .sreg_we(sreg_we_t),
        .d_req(d_req_t), .d_we(d_we_t), .d_ptr_sel(d_ptr_sel_t),
        .mem_timeout(mem_timeout_t), .state(state_t)
    );

    // Packed view: {pc_src, reg_we, sreg_we, d_req, d_we, mem_timeout, state}
    wire [9:0] obs   = {pc_src, reg_we, sreg_we, d_req, d_we, mem_timeout, state};
    wire [9:0] obs_t = {pc_src_t, reg_we_t, sreg_we_t, d_req_t, d_we_t, mem_timeout_t, state_t};

    function automatic logic [9:0] ex(input logic [2:0] pc, input logic rw, input logic sw,
                                      input logic rq, input logic we, input logic mt,
                                      input logic [1:0] st);
        return {pc, rw, sw, rq, we, mt, st};
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        logic [9:0] e;
        RST = 1'b1; instr = 16'h0000; sreg = 8'h00; d_ready = 1'b0;
        #2;
        e = 10'd0;
        n_total++;
        if (obs !== e || jmp !== 16'h0000) $display("FAIL reset_hold obs=%h jmp=%h exp=%h jmp=0000", obs, jmp, e);
        else n_pass++;
        tick;
        RST = 1'b0;
        #1;
        e = ex(3'b000, 0, 0, 0, 0, 0, 2'd0);
        n_total++;
        if (obs !== e) $display("FAIL reset_state got=%h exp=%h", obs, e);
        else n_pass++;
        tick;
        #1;
        e = ex(3'b010, 0, 0, 0, 0, 0, 2'd1);
        n_total++;
        if (obs !== e) $display("FAIL first_exec got=%h exp=%h", obs, e);
        else n_pass++;
        tick;
    endtask

    task automatic test_alu;
        logic [15:0] vec_i [8] = '{16'h0C01, 16'h1C01, 16'h1800, 16'h5000,
                                   16'hE0A5, 16'h0000, 16'h9508, 16'h2C01};
        logic [1:0]  vec_e [8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
        logic [9:0] e;
        for (int i = 0; i < 8; i++) begin
            instr = vec_i[i];
            #1;
            e = ex(3'b010, vec_e[i][1], vec_e[i][0], 0, 0, 0, 2'd1);
            n_total++;
            if (obs !== e) $display("FAIL alu_class instr=%h got=%h exp=%h", instr, obs, e);
            else n_pass++;
            tick;
        end
    endtask

    task automatic test_rjmp;
        logic [15:0] vec_i [4] = '{16'hCFFE, 16'hC7FF, 16'hC000, 16'hC800};
        logic [15:0] vec_j [4] = '{16'hFFFF, 16'h0800, 16'h0001, 16'hF801};
        logic [9:0] e;
        for (int i = 0; i < 4; i++) begin
            instr = vec_i[i];
            #1;
            e = ex(3'b100, 0, 0, 0, 0, 0, 2'd1);
            n_total++;
            if (obs !== e || jmp !== vec_j[i])
                $display("FAIL rjmp instr=%h got=%h jmp=%h exp=%h jmp=%h", instr, obs, jmp, e, vec_j[i]);
            else n_pass++;
            tick;
        end
    endtask

    task automatic test_jmp;
        logic [9:0] e;
        instr = 16'h940C;
        #1;
        e = ex(3'b010, 0, 0, 0, 0, 0, 2'd1);
        n_total++;
        if (obs !== e) $display("FAIL jmp_word1 got=%h exp=%h", obs, e);
        else n_pass++;
        tick;
        instr = 16'h0123;
        #1;
        e = ex(3'b101, 0, 0, 0, 0, 0, 2'd2);
        n_total++;
        if (obs !== e || jmp !== 16'h0123) $display("FAIL jmp_word2 got=%h jmp=%h exp=%h jmp=0123", obs, jmp, e);
        else n_pass++;
        tick;
        instr = 16'h0000;
        #1;
        e = ex(3'b010, 0, 0, 0, 0, 0, 2'd1);
        n_total++;
        if (obs !== e) $display("FAIL jmp_return got=%h exp=%h", obs, e);
        else n_pass++;
        tick;
    endtask

    task automatic test_ld_wait;
        logic [9:0] e;
        instr = 16'h900C;
        for (int i = 0; i < 4; i++) begin
            d_ready = (i == 3);
            #1;
            e = ex((i == 3) ? 3'b010 : 3'b001, (i == 3), 0, 1, 0, 0, (i == 0) ? 2'd1 : 2'd3);
            n_total++;
            if (obs !== e || d_ptr_sel !== 2'd0)
                $display("FAIL ld_wait cyc=%0d got=%h ptr=%0d exp=%h ptr=0", i, obs, d_ptr_sel, e);
            else n_pass++;
            tick;
        end
        instr = 16'h0000; d_ready = 1'b0;
        #1;
        e = ex(3'b010, 0, 0, 0, 0, 0, 2'd1);
        n_total++;
        if (obs !== e) $display("FAIL ld_after got=%h exp=%h", obs, e);
        else n_pass++;
        tick;
    endtask

    task automatic test_st_same_cycle;
        logic [9:0] e;
        instr = 16'h8208; d_ready = 1'b1;
        #1;
        e = ex(3'b010, 0, 0, 1, 1, 0, 2'd1);
        n_total++;
        if (obs !== e || d_ptr_sel !== 2'd1) $display("FAIL st_y_ready got=%h ptr=%0d exp=%h ptr=1", obs, d_ptr_sel, e);
        else n_pass++;
        tick;
        instr = 16'h0000;
        #1;
        e = ex(3'b010, 0, 0, 0, 0, 0, 2'd1);
        n_total++;
        if (obs !== e) $display("FAIL ready_ignored got=%h exp=%h", obs, e);
        else n_pass++;
        tick;
        d_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [9:0] e;
        instr = 16'h920C; d_ready = 1'b0;
        #1;
        e = ex(3'b001, 0, 0, 1, 1, 0, 2'd1);
        n_total++;
        if (obs !== e) $display("FAIL st_x_req got=%h exp=%h", obs, e);
        else n_pass++;
        tick;
        d_ready = 1'b1;
        #1;
        e = ex(3'b010, 0, 0, 1, 1, 0, 2'd3);
        n_total++;
        if (obs !== e || d_ptr_sel !== 2'd0) $display("FAIL st_x_done got=%h ptr=%0d exp=%h ptr=0", obs, d_ptr_sel, e);
        else n_pass++;
        tick;
        instr = 16'h0C01; d_ready = 1'b0;
        #1;
        e = ex(3'b010, 1, 1, 0, 0, 0, 2'd1);
        n_total++;
        if (obs !== e) $display("FAIL add_after_st got=%h exp=%h", obs, e);
        else n_pass++;
        tick;
    endtask

    task automatic test_rst_midwait;
        logic [9:0] e;
        instr = 16'h8000; d_ready = 1'b0;
        #1;
        e = ex(3'b001, 0, 0, 1, 0, 0, 2'd1);
        n_total++;
        if (obs !== e || d_ptr_sel !== 2'd2) $display("FAIL ld_z_req got=%h ptr=%0d exp=%h ptr=2", obs, d_ptr_sel, e);
        else n_pass++;
        tick;
        RST = 1'b1;
        #1;
        e = 10'd0;
        n_total++;
        if (obs !== e || d_ptr_sel !== 2'd0) $display("FAIL rst_midwait got=%h ptr=%0d exp=%h ptr=0", obs, d_ptr_sel, e);
        else n_pass++;
        tick;
        RST = 1'b0; instr = 16'h0000;
        #1;
        e = ex(3'b000, 0, 0, 0, 0, 0, 2'd0);
        n_total++;
        if (obs !== e) $display("FAIL rst_midwait_state got=%h exp=%h", obs, e);
        else n_pass++;
        tick;
        tick;
    endtask

    task automatic test_timeout;
        logic [9:0] e;
        RST = 1'b1; instr = 16'h0000; d_ready = 1'b0;
        tick;
        RST = 1'b0;
        tick;
        instr = 16'h900C;
        #1;
        e = ex(3'b001, 0, 0, 1, 0, 0, 2'd1);
        n_total++;
        if (obs_t !== e) $display("FAIL to_req got=%h exp=%h", obs_t, e);
        else n_pass++;
        tick;
        e = ex(3'b010, 0, 0, 0, 0, 1, 2'd3);
        n_total++;
        if (obs_t !== e) $display("FAIL to_abort got=%h exp=%h", obs_t, e);
        else n_pass++;
        e = ex(3'b001, 0, 0, 1, 0, 0, 2'd3);
        n_total++;
        if (obs !== e) $display("FAIL nolimit_wait got=%h exp=%h", obs, e);
        else n_pass++;
        tick;
        e = ex(3'b001, 0, 0, 1, 0, 0, 2'd1);
        n_total++;
        if (obs_t !== e) $display("FAIL to_rerequest got=%h exp=%h", obs_t, e);
        else n_pass++;
        tick;
        d_ready = 1'b1;
        #1;
        e = ex(3'b010, 1, 0, 1, 0, 0, 2'd3);
        n_total++;
        if (obs_t !== e) $display("FAIL to_ready_wins got=%h exp=%h", obs_t, e);
        else n_pass++;
        n_total++;
        if (obs !== e) $display("FAIL nolimit_done got=%h exp=%h", obs, e);
        else n_pass++;
        tick;
        instr = 16'h0000; d_ready = 1'b0;
        tick;
    endtask

    task automatic test_branch;
        logic [15:0] vec_i [4] = '{16'hF3F9, 16'hF3F9, 16'hF7F9, 16'hF018};
        logic [7:0]  vec_s [4] = '{8'h02, 8'h00, 8'h00, 8'h01};
        logic        vec_t [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] vec_j [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0004};
        logic [9:0]  e;
        logic [15:0] ej;
        for (int i = 0; i < 4; i++) begin
            instr = vec_i[i]; sreg = vec_s[i];
            #1;
`ifdef AVR_BRANCH_EN
            e  = ex(vec_t[i] ? 3'b100 : 3'b010, 0, 0, 0, 0, 0, 2'd1);
            ej = vec_t[i] ? vec_j[i] : 16'h0000;
`else
            e  = ex(3'b010, 0, 0, 0, 0, 0, 2'd1);
            ej = 16'h0000;
`endif
            n_total++;
            if (obs !== e || jmp !== ej)
                $display("FAIL branch instr=%h sreg=%h got=%h jmp=%h exp=%h jmp=%h", instr, sreg, obs, jmp, e, ej);
            else n_pass++;
            tick;
        end
        sreg = 8'h00; instr = 16'h0000;
    endtask

    initial begin
        test_reset;
        test_alu;
        test_rjmp;
        test_jmp;
        test_ld_wait;
        test_st_same_cycle;
        test_back_to_back;
        test_rst_midwait;
        test_timeout;
        test_branch;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
